// File: rtl/long_stack_core_if.sv
// Value stream into the bounded monotonic stack plus its occupancy status.
// Interface only, no timing; with LONG_STACK_DUMP_EN the registered stack image is carried too.
// No backpressure: every valid beat is absorbed.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

interface long_stack_core_if #(
    parameter int MAX_CAP = 12
);
    localparam int SZW = $clog2(MAX_CAP) + 1;

    logic                   data_in_valid;
    logic [`DATA_WIDTH-1:0] data_in;
    logic [`DATA_WIDTH-1:0] nums_left;
    logic                   full;
    logic                   empty;
    logic [SZW-1:0]         size;
`ifdef LONG_STACK_DUMP_EN
    logic [MAX_CAP*`DATA_WIDTH-1:0] stack_flat;
`endif

    modport master (
        output data_in_valid, data_in, nums_left,
`ifdef LONG_STACK_DUMP_EN
        input  stack_flat,
`endif
        input  full, empty, size
    );

    modport slave (
        input  data_in_valid, data_in, nums_left,
`ifdef LONG_STACK_DUMP_EN
        output stack_flat,
`endif
        output full, empty, size
    );
endinterface

// File: rtl/long_stack_core.sv
// Greedy bounded monotonic stack keeping the largest length-MAX_CAP subsequence of a stream.
// Latency 1: each valid value pops/pushes in one cycle, result visible after the next posedge.
// Never stalls (no ready); LONG_STACK_DUMP_EN adds the registered stack_flat image.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module long_stack_core #(
    parameter int MAX_CAP = 12
) (
    input logic               clock,
    input logic               reset,
    long_stack_core_if.slave  bus
);
    localparam int DW  = `DATA_WIDTH;
    localparam int SZW = $clog2(MAX_CAP) + 1;
    localparam int BW  = DW + SZW + 2;

    logic [DW-1:0]        mem_q [MAX_CAP];
    logic [DW-1:0]        mem_d [MAX_CAP];
    logic [SZW-1:0]       size_q;
    logic [SZW-1:0]       size_d;
    logic [SZW-1:0]       cand;
    logic [SZW-1:0]       pops;
    logic [SZW-1:0]       new_size;
    logic signed [BW-1:0] budget;
    logic                 run;
`ifdef LONG_STACK_DUMP_EN
    logic [MAX_CAP*DW-1:0] flat_q;
    logic [MAX_CAP*DW-1:0] flat_d;
`endif

    always_comb begin
        budget = $signed(BW'(size_q)) + $signed(BW'(bus.nums_left)) - $signed(BW'(MAX_CAP));

        // Count only the contiguous run of smaller entries down from the top.
        cand = '0;
        run  = 1'b1;
        for (int i = MAX_CAP - 1; i >= 0; i--) begin
            if (SZW'(i) < size_q) begin
                if (run && (mem_q[i] < bus.data_in)) cand = cand + SZW'(1);
                else                                 run  = 1'b0;
            end
        end

        if (budget < 0)                          pops = '0;
        else if (budget >= $signed(BW'(cand)))   pops = cand;
        else                                     pops = budget[SZW-1:0];

        new_size = size_q - pops;

        mem_d  = mem_q;
        size_d = size_q;
        if (bus.data_in_valid) begin
            if (new_size < SZW'(MAX_CAP)) begin
                for (int i = 0; i < MAX_CAP; i++) begin
                    if (SZW'(i) == new_size) mem_d[i] = bus.data_in;
                end
                size_d = new_size + SZW'(1);
            end else begin
                size_d = SZW'(MAX_CAP);
            end
        end
    end

`ifdef LONG_STACK_DUMP_EN
    always_comb begin
        flat_d = '0;
        for (int i = 0; i < MAX_CAP; i++) begin
            if (SZW'(i) < size_d) flat_d[i*DW +: DW] = mem_d[i];
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            size_q <= '0;
            for (int i = 0; i < MAX_CAP; i++) mem_q[i] <= '0;
`ifdef LONG_STACK_DUMP_EN
            flat_q <= '0;
`endif
        end else begin
            size_q <= size_d;
            for (int i = 0; i < MAX_CAP; i++) mem_q[i] <= mem_d[i];
`ifdef LONG_STACK_DUMP_EN
            flat_q <= flat_d;
`endif
        end
    end

    assign bus.size  = size_q;
    assign bus.full  = (size_q == SZW'(MAX_CAP));
    assign bus.empty = (size_q == '0);
`ifdef LONG_STACK_DUMP_EN
    assign bus.stack_flat = flat_q;
`endif

endmodule

// File: tb/tb_long_stack_core.sv
// Self-checking bench for long_stack_core: directed scenarios then randomized traffic vs a queue model.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module tb_long_stack_core;
    localparam int CAP = 4;
    localparam int DW  = `DATA_WIDTH;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    long_stack_core_if #(.MAX_CAP(CAP)) bus ();
    long_stack_core #(.MAX_CAP(CAP)) dut (.clock(clock), .reset(reset), .bus(bus));

    int n_chk = 0;
    int n_err = 0;
    int model[$];

    task automatic check(input string tag, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Reference: pop smaller tops while budget allows, then push if room.
    task automatic model_step(input int d, input int nl);
        int budget;
        int pops;
        budget = model.size() + nl - CAP;
        if (budget < 0) budget = 0;
        pops = 0;
        while (model.size() > 0 && pops < budget && model[model.size()-1] < d) begin
            void'(model.pop_back());
            pops++;
        end
        if (model.size() < CAP) model.push_back(d);
    endtask

    task automatic check_state(input string tag);
        check({tag, ".size"},  bus.size,  model.size());
        check({tag, ".full"},  bus.full,  model.size() == CAP);
        check({tag, ".empty"}, bus.empty, model.size() == 0);
        for (int i = 0; i < model.size(); i++)
            check($sformatf("%s.mem%0d", tag, i), dut.mem_q[i], model[i]);
    endtask

    task automatic drive(input string tag, input bit rst_n, input bit v, input int d, input int nl);
        @(negedge clock);
        reset             = rst_n;
        bus.data_in_valid = v;
        bus.data_in       = DW'(d);
        bus.nums_left     = DW'(nl);
        @(posedge clock);
        #1;
        if (!rst_n)  model.delete();
        else if (v)  model_step(d, nl);
        check_state(tag);
    endtask

    initial begin
        bus.data_in_valid = 1'b0;
        bus.data_in       = '0;
        bus.nums_left     = '0;

        // Reset held with valid high: reset must win
        repeat (3) drive("reset", 1'b0, 1'b1, 50, 8);
        repeat (2) drive("idle0", 1'b1, 1'b0, 99, 8);

        drive("push30", 1'b1, 1'b1, 30, 8);
        drive("push27", 1'b1, 1'b1, 27, 8);
        drive("push25", 1'b1, 1'b1, 25, 8);
        drive("push20", 1'b1, 1'b1, 20, 8);
        check("full_after4", bus.full, 1);
        repeat (4) drive("low16", 1'b1, 1'b1, 16, 8);
        drive("tie25", 1'b1, 1'b1, 25, 8);
        check("tie25.top", dut.mem_q[3], 25);
        check("tie25.mem2", dut.mem_q[2], 25);
        repeat (3) drive("hold", 1'b1, 1'b0, 0, 8);

        // Budget limit
        drive("rst_b", 1'b0, 1'b0, 0, 8);
        drive("b5", 1'b1, 1'b1, 5, 8);
        drive("b4", 1'b1, 1'b1, 4, 8);
        drive("b3", 1'b1, 1'b1, 3, 8);
        drive("b2", 1'b1, 1'b1, 2, 8);
        drive("budget1", 1'b1, 1'b1, 9, 1);
        check("budget1.top", dut.mem_q[3], 9);
        check("budget1.mem2", dut.mem_q[2], 3);

        // Multi-pop down to empty, then push
        drive("rst_e", 1'b0, 1'b0, 0, 8);
        drive("e3", 1'b1, 1'b1, 3, 8);
        drive("e1", 1'b1, 1'b1, 1, 8);
        drive("e7", 1'b1, 1'b1, 7, 8);
        check("e7.size", bus.size, 1);
        drive("midrst", 1'b0, 1'b1, 11, 8);
        drive("first_after_rst", 1'b1, 1'b1, 2, 0);

        // Randomized traffic with occasional resets and zero/small nums_left
        for (int k = 0; k < 400; k++) begin
            drive("rand",
                  ($urandom_range(0, 40) != 0),
                  ($urandom_range(0, 3) != 0),
                  int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 9)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
